// File: rtl/uart_cmd_framer.sv
// uart_cmd_framer
//   Assembles the UART RX byte stream into 5-byte command frames
//   (cmd, addrLsb, addrMsb, dataLsb, dataMsb) for spi_master_top.
//   A complete frame is published on the o_* outputs together with a
//   1-cycle cmdUpdate strobe.  A partial frame whose inter-byte gap
//   exceeds TIMEOUT_CLKS is discarded and flagged on frame_err.
//
// Ports
//   clk40M       in   system clock, 40 MHz
//   nRst         in   asynchronous active-low reset
//   rx_dv        in   1-cycle strobe, rx_byte valid
//   rx_byte      in   received byte
//   i_dst_ready  in   downstream can take a frame (tie 1 when unused)
//   cmdUpdate    out  1-cycle strobe, o_* hold a new complete frame
//   o_cmd        out  frame byte 0
//   o_addrLsb    out  frame byte 1
//   o_addrMsb    out  frame byte 2
//   o_dataLsb    out  frame byte 3
//   o_dataMsb    out  frame byte 4
//   frame_err    out  1-cycle strobe, partial frame dropped on timeout
//   overrun      out  1-cycle strobe, byte dropped while a frame is pending
module uart_cmd_framer #(
   parameter int unsigned TIMEOUT_CLKS = 40000,
   parameter int unsigned FRAME_BYTES  = 5
) (
   input  logic       clk40M,
   input  logic       nRst,
   input  logic       rx_dv,
   input  logic [7:0] rx_byte,
   input  logic       i_dst_ready,
   output logic       cmdUpdate,
   output logic [7:0] o_cmd,
   output logic [7:0] o_addrLsb,
   output logic [7:0] o_addrMsb,
   output logic [7:0] o_dataLsb,
   output logic [7:0] o_dataMsb,
   output logic       frame_err,
   output logic       overrun
);

   localparam int unsigned CW       = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [2:0]  LAST_IDX = 3'(FRAME_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      PUBLISH = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    buf_q [4];
   logic [7:0]    buf_d [4];
   logic [7:0]    o_cmd_q, o_cmd_d;
   logic [7:0]    o_addr_lsb_q, o_addr_lsb_d;
   logic [7:0]    o_addr_msb_q, o_addr_msb_d;
   logic [7:0]    o_data_lsb_q, o_data_lsb_d;
   logic [7:0]    o_data_msb_q, o_data_msb_d;
   logic          frame_err_q, frame_err_d;
   logic          overrun_q, overrun_d;
   logic          cmd_update;

   // An overrun flagged in the cycle the downstream becomes ready holds the
   // publish off by one cycle so cmdUpdate and overrun never coincide.
   assign cmd_update = (state_q == PUBLISH) & i_dst_ready & ~overrun_q;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      buf_d        = buf_q;
      o_cmd_d      = o_cmd_q;
      o_addr_lsb_d = o_addr_lsb_q;
      o_addr_msb_d = o_addr_msb_q;
      o_data_lsb_d = o_data_lsb_q;
      o_data_msb_d = o_data_msb_q;
      frame_err_d  = 1'b0;
      overrun_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (rx_dv) begin
               buf_d[0] = rx_byte;
               idx_d    = 3'd1;
               cnt_d    = CW'(TIMEOUT_CLKS);
               state_d  = COLLECT;
            end
         end

         COLLECT: begin
            if (rx_dv) begin
               cnt_d = CW'(TIMEOUT_CLKS);
               if (idx_q == LAST_IDX) begin
                  // Last byte bypasses the buffer and lands straight in o_*.
                  o_cmd_d      = buf_q[0];
                  o_addr_lsb_d = buf_q[1];
                  o_addr_msb_d = buf_q[2];
                  o_data_lsb_d = buf_q[3];
                  o_data_msb_d = rx_byte;
                  idx_d        = 3'd0;
                  state_d      = PUBLISH;
               end else begin
                  buf_d[idx_q[1:0]] = rx_byte;
                  idx_d             = idx_q + 3'd1;
               end
            end else if (cnt_q <= CW'(1)) begin
               // Gap expired: drop the partial frame, counter rests at 0.
               cnt_d       = '0;
               frame_err_d = 1'b1;
               idx_d       = 3'd0;
               state_d     = IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         PUBLISH: begin
            if (rx_dv) begin
               overrun_d = 1'b1;
            end
            if (cmd_update) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk40M or negedge nRst) begin
      if (!nRst) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         cnt_q        <= '0;
         for (int unsigned i = 0; i < 4; i++) begin
            buf_q[i] <= '0;
         end
         o_cmd_q      <= '0;
         o_addr_lsb_q <= '0;
         o_addr_msb_q <= '0;
         o_data_lsb_q <= '0;
         o_data_msb_q <= '0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         buf_q        <= buf_d;
         o_cmd_q      <= o_cmd_d;
         o_addr_lsb_q <= o_addr_lsb_d;
         o_addr_msb_q <= o_addr_msb_d;
         o_data_lsb_q <= o_data_lsb_d;
         o_data_msb_q <= o_data_msb_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign cmdUpdate = cmd_update;
   assign o_cmd     = o_cmd_q;
   assign o_addrLsb = o_addr_lsb_q;
   assign o_addrMsb = o_addr_msb_q;
   assign o_dataLsb = o_data_lsb_q;
   assign o_dataMsb = o_data_msb_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule
